mem_compare_engine: RTL and testbench
=====================================

MEM_COMPARE_ENGINE -- requirements
Module: mem_compare_engine

Interface
REQ-001 Parameter NUM_CH, default 2, number of result/golden memory pairs compared in parallel (1..8).
REQ-002 Parameter DATA_W, default 32, memory word width in bits (multiple of 8).
REQ-003 Parameter ADDR_W, default 32, word-address width.
REQ-004 Parameter RD_LAT, default 1, memory read latency in cycles from R_req to valid data (1..4).
REQ-005 Parameter CNT_W, default 16, width of the error counter.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  one-cycle pulse that begins a compare pass; sampled only in IDLE.
REQ-009 len  in  ADDR_W  number of words to compare per channel; sampled with start.
REQ-010 R_req  out  1  read strobe, shared by all 2*NUM_CH memories.
REQ-011 addr  out  ADDR_W  word address, shared by all memories.
REQ-012 dut_R_data  in  NUM_CH*DATA_W  result-memory read data; channel k at bits [k*DATA_W +: DATA_W].
REQ-013 gold_R_data  in  NUM_CH*DATA_W  golden-memory read data, same packing.
REQ-014 busy  out  1  high from the cycle after an accepted start until finish.
REQ-015 finish  out  1  one-cycle pulse when the pass completes.
REQ-016 pass  out  1  high when the last completed pass had zero mismatches.
REQ-017 err_cnt  out  CNT_W  mismatching words in the last or current pass.
REQ-018 first_err_addr  out  ADDR_W  address of the first mismatch.
REQ-019 first_err_ch  out  3  lowest channel index that mismatched at first_err_addr.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-021 IDLE + start: len latched, err_cnt and first_err_* cleared, pass cleared; next state ISSUE, or DONE when len==0.
REQ-022 In ISSUE, R_req=1 every cycle with addr = 0,1,...,len-1; after addr len-1 -> DRAIN.
REQ-023 Outside ISSUE, R_req=0 and addr holds its last value.
REQ-024 A valid/address pipeline of depth RD_LAT SHALL align each issued address with its returned data; data is compared exactly RD_LAT cycles after its R_req.
REQ-025 Per compared cycle: err_cnt += count of channels where dut word != gold word (full DATA_W compare); saturate at 2^CNT_W-1, no wrap.
REQ-026 The first compared cycle with any mismatch captures first_err_addr and the lowest mismatching channel into first_err_ch; later mismatches leave them unchanged.
REQ-027 DRAIN -> DONE when the pipeline is empty (RD_LAT cycles after the last R_req).
REQ-028 DONE: finish=1 for exactly one cycle, pass=(err_cnt==0), then -> IDLE; pass/err_cnt/first_err_* hold until the next accepted start.
REQ-029 start while busy or in DONE SHALL be ignored.
REQ-030 Latency: finish asserts len+RD_LAT+1 cycles after the start cycle for len>0, and 1 cycle after for len==0.
REQ-031 When no mismatch occurs, first_err_addr and first_err_ch SHALL stay 0.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, R_req=0, addr=0, busy=0, finish=0, pass=0, err_cnt=0, first_err_addr=0, first_err_ch=0, pipeline valid bits cleared.
REQ-033 Reset mid-pass SHALL abort it with no finish pulse; in-flight read data is discarded.

Configuration
REQ-034 Macro CMP_EARLY_ABORT_EN: when defined, the first mismatch forces ISSUE/DRAIN to stop issuing, drain the pipeline (counting in-flight words), and then enter DONE.
REQ-035 When CMP_EARLY_ABORT_EN is defined, err_cnt counts mismatches among the words already issued before the abort; when undefined, all len words are always compared.

Verification
REQ-036 NUM_CH=2, len=196, memories identical -> finish at cycle 198 (RD_LAT=1), pass=1, err_cnt=0.
REQ-037 Golden ch1 word 17 altered, len=196 -> err_cnt=1, first_err_addr=17, first_err_ch=1, pass=0; with CMP_EARLY_ABORT_EN, R_req stops within 1 cycle of the compare at addr 17.
REQ-038 len=0 -> no R_req, finish the cycle after start, pass=1.
REQ-039 CNT_W=4, 20 mismatching words -> err_cnt=15 (saturated).
REQ-040 rst asserted at addr 50 -> all outputs reset next cycle, no finish; a new start then runs a clean pass.
REQ-041 RD_LAT=3, start pulsed during ISSUE -> ignored; comparisons stay aligned and finish is at len+4.

Source files
------------

// File: rtl/mem_compare_engine.sv
// Streams len words from NUM_CH result/golden memory pairs and counts mismatching words.
// Optional CMP_EARLY_ABORT_EN: stop issuing reads at the first mismatch, drain, then finish.
module mem_compare_engine #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        len,
    output logic                     R_req,
    output logic [ADDR_W-1:0]        addr,
    input  logic [NUM_CH*DATA_W-1:0] dut_R_data,
    input  logic [NUM_CH*DATA_W-1:0] gold_R_data,
    output logic                     busy,
    output logic                     finish,
    output logic                     pass,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [ADDR_W-1:0]        first_err_addr,
    output logic [2:0]               first_err_ch
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] len_q;
    logic              first_seen;
    logic [RD_LAT-1:0] vld_pipe;
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];

    logic              cmp_vld;
    logic              any_mis;
    logic [3:0]        mis_cnt;
    logic [2:0]        low_ch;
    logic              inflight;
    logic              abort;
    logic [CNT_W+3:0]  sat_sum;
    logic [CNT_W-1:0]  err_nxt;

    always_comb begin
        mis_cnt = '0;
        low_ch  = '0;
        any_mis = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (dut_R_data[k*DATA_W +: DATA_W] != gold_R_data[k*DATA_W +: DATA_W]) begin
                if (!any_mis) low_ch = 3'(k);
                any_mis = 1'b1;
                mis_cnt = mis_cnt + 4'd1;
            end
        end
        cmp_vld = vld_pipe[RD_LAT-1];
        // Words in stages before the last are still outstanding; the last stage is compared this cycle.
        inflight = 1'b0;
        for (int unsigned i = 0; i < RD_LAT - 1; i++) inflight = inflight | vld_pipe[i];
        sat_sum = {4'b0, err_cnt} + {{CNT_W{1'b0}}, mis_cnt};
        if (!cmp_vld)
            err_nxt = err_cnt;
        else if (sat_sum[CNT_W+3:CNT_W] != 4'b0)
            err_nxt = '1;
        else
            err_nxt = sat_sum[CNT_W-1:0];
`ifdef CMP_EARLY_ABORT_EN
        abort = cmp_vld && any_mis;
`else
        abort = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= R_req;
            for (int unsigned i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        addr_pipe[0] <= addr;
        for (int unsigned i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            len_q          <= '0;
            first_seen     <= 1'b0;
            R_req          <= 1'b0;
            addr           <= '0;
            busy           <= 1'b0;
            finish         <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_ch   <= '0;
        end else begin
            finish  <= 1'b0;
            err_cnt <= err_nxt;
            if (cmp_vld && any_mis && !first_seen) begin
                first_seen     <= 1'b1;
                first_err_addr <= addr_pipe[RD_LAT-1];
                first_err_ch   <= low_ch;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q          <= len;
                        err_cnt        <= '0;
                        first_seen     <= 1'b0;
                        first_err_addr <= '0;
                        first_err_ch   <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        if (len == '0) begin
                            state  <= DONE;
                            finish <= 1'b1;
                            pass   <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            R_req <= 1'b1;
                            addr  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (abort || addr == len_q - ADDR_W'(1)) begin
                        R_req <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // pass uses the count including this cycle's final compare so it lines up with finish.
                    if (!inflight) begin
                        state  <= DONE;
                        finish <= 1'b1;
                        pass   <= (err_nxt == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_compare_engine.sv
// Scoreboard bench for mem_compare_engine: a driver pushes expected pass results from a
// behavioural model over the memory arrays; a monitor pops and checks them on each finish.
module tb_mem_compare_engine;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 3;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 256;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [ADDR_W-1:0]        len;
    logic                     R_req;
    logic [ADDR_W-1:0]        addr;
    logic [NUM_CH*DATA_W-1:0] dut_R_data;
    logic [NUM_CH*DATA_W-1:0] gold_R_data;
    logic                     busy;
    logic                     finish;
    logic                     pass;
    logic [CNT_W-1:0]         err_cnt;
    logic [ADDR_W-1:0]        first_err_addr;
    logic [2:0]               first_err_ch;

    always #5 clk = ~clk;

    mem_compare_engine #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .R_req(R_req), .addr(addr),
        .dut_R_data(dut_R_data), .gold_R_data(gold_R_data), .busy(busy), .finish(finish),
        .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr), .first_err_ch(first_err_ch)
    );

    // Memory models: data for a request appears RD_LAT cycles later; junk otherwise.
    logic [DATA_W-1:0] dmem [NUM_CH][DEPTH];
    logic [DATA_W-1:0] gmem [NUM_CH][DEPTH];
    logic [RD_LAT-1:0] rq_v = '0;
    logic [ADDR_W-1:0] rq_a [RD_LAT];
    logic [DATA_W-1:0] junk_d = '0;
    logic [DATA_W-1:0] junk_g = '1;

    always @(posedge clk) begin
        rq_v[0] <= (R_req === 1'b1);
        rq_a[0] <= addr;
        for (int i = 1; i < RD_LAT; i++) begin
            rq_v[i] <= rq_v[i-1];
            rq_a[i] <= rq_a[i-1];
        end
        junk_d <= $urandom;
        junk_g <= $urandom;
    end

    always_comb begin
        dut_R_data  = '0;
        gold_R_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rq_v[RD_LAT-1]) begin
                dut_R_data[c*DATA_W +: DATA_W]  = dmem[c][rq_a[RD_LAT-1][7:0]];
                gold_R_data[c*DATA_W +: DATA_W] = gmem[c][rq_a[RD_LAT-1][7:0]];
            end else begin
                dut_R_data[c*DATA_W +: DATA_W]  = junk_d;
                gold_R_data[c*DATA_W +: DATA_W] = junk_g;
            end
        end
    end

    typedef struct {
        int unsigned n_req;
        int unsigned lat;
        int unsigned errs;
        logic        pass;
        int unsigned fa;
        int unsigned fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   req_cnt = 0;
    int   exp_addr = 0;
    bit   addr_bad = 0;
    bit   finish_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: walk the words in order, count mismatching channels, clamp the total.
    function automatic exp_t model(input int l);
        exp_t e;
        int   n = l;
        int   errs = 0;
        bit   found = 0;
        e.fa = 0;
        e.fc = 0;
        for (int a = 0; a < n; a++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (dmem[c][a] != gmem[c][a]) begin
                    errs++;
                    if (!found) begin
                        found = 1;
                        e.fa  = a;
                        e.fc  = c;
`ifdef CMP_EARLY_ABORT_EN
                        n = (a + RD_LAT + 1 < l) ? a + RD_LAT + 1 : l;
`endif
                    end
                end
            end
        end
        e.n_req = n;
        e.errs  = (errs > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : errs;
        e.pass  = (errs == 0);
        e.lat   = (l == 0) ? 1 : n + RD_LAT + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (R_req === 1'b1) begin
            if (addr != ADDR_W'(exp_addr)) addr_bad = 1;
            exp_addr++;
            req_cnt++;
        end
        if (finish === 1'b1) begin
            finish_seen = 1;
            if (sb.size() == 0) begin
                check("unexpected_finish", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("finish_latency", cyc - start_cyc, mon_e.lat);
                check("req_count", req_cnt, mon_e.n_req);
                check("addr_sequence_bad", addr_bad, 0);
                check("err_cnt", err_cnt, mon_e.errs);
                check("pass", pass, mon_e.pass);
                check("first_err_addr", first_err_addr, mon_e.fa);
                check("first_err_ch", first_err_ch, mon_e.fc);
            end
        end
    end

    task automatic fill();
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < DEPTH; a++) begin
                gmem[c][a] = $urandom;
                dmem[c][a] = gmem[c][a];
            end
    endtask

    task automatic flip(input int a, input int c);
        dmem[c][a] = dmem[c][a] ^ (DATA_W'(1) << $urandom_range(DATA_W - 1));
    endtask

    task automatic issue_start(input int l);
        @(posedge clk);
        #1;
        start       = 1;
        len         = ADDR_W'(l);
        start_cyc   = cyc;
        req_cnt     = 0;
        exp_addr    = 0;
        addr_bad    = 0;
        finish_seen = 0;
        @(posedge clk);
        #1;
        start = 0;
        len   = ADDR_W'($urandom);
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_pass(input int l, input bit mid_pulse);
        exp_t e;
        e = model(l);
        sb.push_back(e);
        issue_start(l);
        for (int i = 0; i < l + RD_LAT + 20 && !finish_seen; i++) begin
            @(posedge clk);
            if (mid_pulse && i == 5) begin
                #1 start = 1;
                @(posedge clk);
                #1 start = 0;
            end
        end
        @(negedge clk);
        if (!finish_seen) begin
            check("finish_timeout", 0, 1);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        check("hold_err_cnt", err_cnt, e.errs);
        check("hold_pass", pass, e.pass);
        check("idle_busy", busy, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_R_req"}, R_req, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finish"}, finish, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_first_err_addr"}, first_err_addr, 0);
        check({tag, "_first_err_ch"}, first_err_ch, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1;
        start = 0;
        len   = '0;
        fill();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check_reset_state("reset");

        // Identical memories, long pass.
        run_pass(196, 0);

        // Single altered golden word on channel 1.
        fill();
        gmem[1][17] = gmem[1][17] ^ 32'h0000_0100;
        run_pass(196, 0);

        // Zero-length pass.
        run_pass(0, 0);

        // 20 mismatching words saturate a 4-bit counter.
        fill();
        for (int k = 0; k < 10; k++) begin
            flip(k * 7 + 3, 0);
            flip(k * 7 + 3, 1);
        end
        run_pass(100, 0);

        // Start pulse during ISSUE must be ignored.
        fill();
        flip(12, 1);
        flip(40, 0);
        run_pass(60, 1);

        // Reset mid-pass at addr 50: outputs clear, no finish.
        fill();
        flip(10, 0);
        issue_start(150);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (R_req === 1'b1 && addr == ADDR_W'(50)) break;
        end
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        check_reset_state("midpass_reset");
        finish_seen = 0;
        repeat (20) @(negedge clk);
        check("no_finish_after_reset", finish_seen, 0);

        // Clean pass after the reset.
        fill();
        run_pass(80, 0);

        // Randomised passes with sparse mismatches.
        for (int t = 0; t < 8; t++) begin
            int l;
            int nf;
            l = $urandom_range(1, 120);
            fill();
            nf = (t < 2) ? 0 : $urandom_range(1, 4);
            for (int k = 0; k < nf; k++) flip($urandom_range(l - 1), $urandom_range(NUM_CH - 1));
            run_pass(l, (l > 12) ? bit'($urandom_range(1)) : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
